// File: rtl/alu_reservation_station.sv
// Reservation station for the integer ALU path: holds instructions until both operands arrive,
// snoops the ALU and LSB CDBs, and dispatches the lowest-index ready entry each cycle.
module alu_reservation_station #(
  parameter int ENTRY_NUM = 16,
  parameter int OP_W      = 6,
  parameter int DATA_W    = 32,
  parameter int ROB_W     = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_pc,
  input  logic [DATA_W-1:0] issue_imm,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic              issue_qj_busy,
  input  logic [ROB_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              issue_qk_busy,
  input  logic [ROB_W-1:0]  issue_qk,
  input  logic [ROB_W-1:0]  issue_reorder,
  output logic              full_out,
  input  logic              cdb_alu_valid,
  input  logic [ROB_W-1:0]  cdb_alu_reorder,
  input  logic [DATA_W-1:0] cdb_alu_result,
  input  logic              cdb_lsb_valid,
  input  logic [ROB_W-1:0]  cdb_lsb_reorder,
  input  logic [DATA_W-1:0] cdb_lsb_result,
  output logic              alu_enable,
  output logic [OP_W-1:0]   alu_type,
  output logic [DATA_W-1:0] alu_pc,
  output logic [DATA_W-1:0] alu_imm,
  output logic [DATA_W-1:0] alu_rs,
  output logic [DATA_W-1:0] alu_rt,
  output logic [ROB_W-1:0]  alu_reorder
);

  localparam int IDX_W = $clog2(ENTRY_NUM);

  logic [ENTRY_NUM-1:0] busy, qj_busy, qk_busy;
  logic [OP_W-1:0]      op      [ENTRY_NUM];
  logic [DATA_W-1:0]    pc      [ENTRY_NUM];
  logic [DATA_W-1:0]    imm     [ENTRY_NUM];
  logic [DATA_W-1:0]    vj      [ENTRY_NUM];
  logic [DATA_W-1:0]    vk      [ENTRY_NUM];
  logic [ROB_W-1:0]     qj      [ENTRY_NUM];
  logic [ROB_W-1:0]     qk      [ENTRY_NUM];
  logic [ROB_W-1:0]     reorder [ENTRY_NUM];

  logic             free_found, ready_found, do_issue, advance;
  logic [IDX_W-1:0] free_idx, ready_idx;
  logic [DATA_W-1:0] new_vj, new_vk;
  logic             new_qj_busy, new_qk_busy;

  assign full_out = &busy;
  assign advance  = rdy_in && !clear_in;
  assign do_issue = advance && issue_valid && !full_out;

  // Priority encoders: lowest free slot for issue, lowest ready slot for dispatch.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    ready_found = 1'b0;
    ready_idx   = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (!busy[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (busy[i] && !qj_busy[i] && !qk_busy[i] && !ready_found) begin
        ready_found = 1'b1;
        ready_idx   = IDX_W'(i);
      end
    end
  end

  // Issue-time bypass: an operand broadcast in the issue cycle is captured directly.
  always_comb begin
    new_vj      = issue_vj;
    new_qj_busy = issue_qj_busy;
    new_vk      = issue_vk;
    new_qk_busy = issue_qk_busy;
    if (issue_qj_busy && cdb_alu_valid && cdb_alu_reorder == issue_qj) begin
      new_vj      = cdb_alu_result;
      new_qj_busy = 1'b0;
    end else if (issue_qj_busy && cdb_lsb_valid && cdb_lsb_reorder == issue_qj) begin
      new_vj      = cdb_lsb_result;
      new_qj_busy = 1'b0;
    end
    if (issue_qk_busy && cdb_alu_valid && cdb_alu_reorder == issue_qk) begin
      new_vk      = cdb_alu_result;
      new_qk_busy = 1'b0;
    end else if (issue_qk_busy && cdb_lsb_valid && cdb_lsb_reorder == issue_qk) begin
      new_vk      = cdb_lsb_result;
      new_qk_busy = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy    <= '0;
      qj_busy <= '0;
      qk_busy <= '0;
    end else if (clear_in) begin
      busy <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (busy[i] && qj_busy[i] &&
            ((cdb_alu_valid && cdb_alu_reorder == qj[i]) ||
             (cdb_lsb_valid && cdb_lsb_reorder == qj[i])))
          qj_busy[i] <= 1'b0;
        if (busy[i] && qk_busy[i] &&
            ((cdb_alu_valid && cdb_alu_reorder == qk[i]) ||
             (cdb_lsb_valid && cdb_lsb_reorder == qk[i])))
          qk_busy[i] <= 1'b0;
      end
      if (ready_found)
        busy[ready_idx] <= 1'b0;
      if (do_issue) begin
        busy[free_idx]    <= 1'b1;
        qj_busy[free_idx] <= new_qj_busy;
        qk_busy[free_idx] <= new_qk_busy;
      end
    end
  end

  // Payload carries no reset; it is only meaningful while the matching busy bit is set.
  always_ff @(posedge clk_in) begin
    if (advance) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (busy[i] && qj_busy[i]) begin
          if (cdb_alu_valid && cdb_alu_reorder == qj[i])      vj[i] <= cdb_alu_result;
          else if (cdb_lsb_valid && cdb_lsb_reorder == qj[i]) vj[i] <= cdb_lsb_result;
        end
        if (busy[i] && qk_busy[i]) begin
          if (cdb_alu_valid && cdb_alu_reorder == qk[i])      vk[i] <= cdb_alu_result;
          else if (cdb_lsb_valid && cdb_lsb_reorder == qk[i]) vk[i] <= cdb_lsb_result;
        end
      end
      if (do_issue) begin
        op[free_idx]      <= issue_op;
        pc[free_idx]      <= issue_pc;
        imm[free_idx]     <= issue_imm;
        vj[free_idx]      <= new_vj;
        vk[free_idx]      <= new_vk;
        qj[free_idx]      <= issue_qj;
        qk[free_idx]      <= issue_qk;
        reorder[free_idx] <= issue_reorder;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      alu_enable  <= 1'b0;
      alu_type    <= '0;
      alu_pc      <= '0;
      alu_imm     <= '0;
      alu_rs      <= '0;
      alu_rt      <= '0;
      alu_reorder <= '0;
    end else if (advance && ready_found) begin
      alu_enable  <= 1'b1;
      alu_type    <= op[ready_idx];
      alu_pc      <= pc[ready_idx];
      alu_imm     <= imm[ready_idx];
      alu_rs      <= vj[ready_idx];
      alu_rt      <= vk[ready_idx];
      alu_reorder <= reorder[ready_idx];
    end else begin
      alu_enable <= 1'b0;
    end
  end

endmodule
